// File: rtl/button_pkg.sv
// Shared constants for the button event stage: state encoding and default timing.
package button_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_WAIT   = ST_WAIT,
    S_REPEAT = ST_REPEAT
  } btn_state_e;

  localparam int HOLD_DLY_DEF = 95;
  localparam int REP_PER_DEF  = 19;
  localparam int CW_DEF       = 8;

endpackage

// File: rtl/button_event_fsm.sv
// One button channel: press/release/auto-repeat pulse FSM, hold counter and sticky pend flag.
module button_event_fsm
  import button_pkg::*;
#(
  parameter int HOLD_DLY = HOLD_DLY_DEF,
  parameter int REP_PER  = REP_PER_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic cclk_i,
  input  logic clr_i,
  input  logic inp_i,
  input  logic ack_i,
  output logic press_o,
  output logic release_o,
  output logic rpt_o,
  output logic held_o,
  output logic pend_o
);

  // Counter restarts at 0 on the press edge, so the terminal value HOLD_DLY-1
  // lands the first rpt pulse exactly HOLD_DLY cycles after the press pulse.
  localparam logic [CW-1:0] HOLD_TERM = CW'(HOLD_DLY - 1);
  localparam logic [CW-1:0] REP_TERM  = (REP_PER > 0) ? CW'(REP_PER - 1) : '0;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rpt_q, rpt_d;
  logic          held_q, held_d;
  logic          pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    held_d  = inp_i;
    case (state_q)
      S_IDLE: begin
        if (inp_i) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!inp_i) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_TERM) begin
          // With repeat disabled the counter parks at its terminal value.
          if (REP_PER != 0) begin
            rpt_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!inp_i) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == REP_TERM) begin
          rpt_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A new event in the same cycle as ack wins so nothing is lost.
    pend_d = press_d | rpt_d | (pend_q & ~ack_i);
  end

  always_ff @(posedge cclk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
      pend_q  <= pend_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = rel_q;
  assign rpt_o     = rpt_q;
  assign held_o    = held_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/button_events.sv
// Debounced button levels to registered press/release/repeat pulses, N independent channels.
module button_events
  import button_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_DLY = HOLD_DLY_DEF,
  parameter int REP_PER  = REP_PER_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic         cclk_i,
  input  logic         clr_i,
  input  logic [N-1:0] inp_i,
  input  logic [N-1:0] ack_i,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] rpt_o,
  output logic [N-1:0] held_o,
  output logic [N-1:0] pend_o
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_event_fsm #(
      .HOLD_DLY(HOLD_DLY),
      .REP_PER (REP_PER),
      .CW      (CW)
    ) u_ch (
      .cclk_i   (cclk_i),
      .clr_i    (clr_i),
      .inp_i    (inp_i[i]),
      .ack_i    (ack_i[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .rpt_o    (rpt_o[i]),
      .held_o   (held_o[i]),
      .pend_o   (pend_o[i])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// Randomised and directed bench for button_events against an event-rule reference model.
module tb_button_events;
  localparam int N  = 4;
  localparam int HD = 4;

  logic       cclk = 1'b0;
  logic       clr;
  logic [3:0] inp_a, ack_a, inp_b, ack_b;
  logic [3:0] press_a, rel_a, rpt_a, held_a, pend_a;
  logic [3:0] press_b, rel_b, rpt_b, held_b, pend_b;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = REP_PER 2 build, index 1 = REP_PER 0 build.
  logic [3:0] m_prev [2];
  logic [3:0] m_pend [2];
  logic [3:0] e_press[2];
  logic [3:0] e_rel  [2];
  logic [3:0] e_rpt  [2];
  logic [3:0] e_held [2];
  int         m_run  [2][N];

  always #5 cclk = ~cclk;

  button_events #(.N(N), .HOLD_DLY(HD), .REP_PER(2), .CW(8)) dut_a (
    .cclk_i(cclk), .clr_i(clr), .inp_i(inp_a), .ack_i(ack_a),
    .press_o(press_a), .release_o(rel_a), .rpt_o(rpt_a), .held_o(held_a), .pend_o(pend_a)
  );

  button_events #(.N(N), .HOLD_DLY(HD), .REP_PER(0), .CW(8)) dut_b (
    .cclk_i(cclk), .clr_i(clr), .inp_i(inp_b), .ack_i(ack_b),
    .press_o(press_b), .release_o(rel_b), .rpt_o(rpt_b), .held_o(held_b), .pend_o(pend_b)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d] = '0; m_pend[d] = '0; e_press[d] = '0;
      e_rel[d]  = '0; e_rpt[d]  = '0; e_held[d]  = '0;
      for (int i = 0; i < N; i++) m_run[d][i] = 0;
    end
  endtask

  // Events follow from the sampled level history: edges give press/release,
  // and the length of the current high run decides repeat pulses.
  task automatic model_edge(input int d, input int rp, input logic [3:0] lv, input logic [3:0] ak);
    for (int i = 0; i < N; i++) begin
      logic p, r, t;
      p = lv[i] & ~m_prev[d][i];
      r = ~lv[i] & m_prev[d][i];
      if (!lv[i])  m_run[d][i] = 0;
      else if (p)  m_run[d][i] = 0;
      else         m_run[d][i] = m_run[d][i] + 1;
      t = lv[i] && !p && rp > 0 && m_run[d][i] >= HD && ((m_run[d][i] - HD) % rp) == 0;
      e_press[d][i] = p;
      e_rel[d][i]   = r;
      e_rpt[d][i]   = t;
      e_held[d][i]  = lv[i];
      if (p || t)      m_pend[d][i] = 1'b1;
      else if (ak[i])  m_pend[d][i] = 1'b0;
      m_prev[d][i] = lv[i];
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.press", press_a, e_press[0]); chk("a.release", rel_a, e_rel[0]);
    chk("a.rpt", rpt_a, e_rpt[0]);       chk("a.held", held_a, e_held[0]);
    chk("a.pend", pend_a, m_pend[0]);
    chk("b.press", press_b, e_press[1]); chk("b.release", rel_b, e_rel[1]);
    chk("b.rpt", rpt_b, e_rpt[1]);       chk("b.held", held_b, e_held[1]);
    chk("b.pend", pend_b, m_pend[1]);
    chk("a.excl", (press_a & rel_a) | (press_a & rpt_a) | (rel_a & rpt_a), 4'b0000);
  endtask

  task automatic step(input logic [3:0] ia, input logic [3:0] aa,
                      input logic [3:0] ib, input logic [3:0] ab);
    inp_a = ia; ack_a = aa; inp_b = ib; ack_b = ab;
    @(posedge cclk);
    model_edge(0, 2, ia, aa);
    model_edge(1, 0, ib, ab);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] ra, rb;
    int rpt_cnt, press_cnt;
    clr = 1'b1; inp_a = 4'b1111; ack_a = '0; inp_b = 4'b1111; ack_b = '0;
    model_reset();
    repeat (3) @(posedge cclk);
    #1 check_all();

    // Buttons already held when reset lifts produce a fresh press.
    @(negedge cclk); clr = 1'b0;
    step(4'b1111, 4'b0000, 4'b1111, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b1111, 4'b0000, 4'b1111);

    // Long hold on ch0 with ack every cycle: collisions with rpt keep pend set.
    for (int k = 0; k < 14; k++) step(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0001, 4'b0000, 4'b0000);

    // Short tap on ch2, then ack.
    step(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0100, 4'b0000, 4'b0000);

    // 1-cycle-high pulse, then a 1-cycle-low glitch on ch1 while repeating.
    step(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 8; k++) step(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++) step(4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0010, 4'b0000, 4'b0000);

    // Repeat-disabled build: 50-cycle hold on ch3 gives one press, no rpt.
    rpt_cnt = 0; press_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step(4'b0000, 4'b0000, 4'b1000, 4'b0000);
      rpt_cnt += int'(rpt_b[3]); press_cnt += int'(press_b[3]);
    end
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("b.press_count", 4'(press_cnt), 4'd1);
    chk("b.rpt_count", 4'(rpt_cnt), 4'd0);

    // Asynchronous reset in the middle of a hold.
    for (int k = 0; k < 7; k++) step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    #2 clr = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge cclk); clr = 1'b0;
    for (int k = 0; k < 6; k++) step(4'b0001, 4'b0000, 4'b0001, 4'b0000);

    // Random levels with slow toggling and random acks.
    ra = 4'b0000; rb = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) ra[i] = ~ra[i];
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      end
      step(ra, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           rb, 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
